// File: rtl/turbo_pkg.sv
// Shared widths, FSM states and serial bit ordering for the turbo encoder output stage.
package turbo_pkg;

   localparam int DEF_NIB_W = 4;
   localparam int DEF_DEPTH = 16;

   typedef enum logic [1:0] {
      REARM = 2'd0,
      IDLE  = 2'd1,
      FILL  = 2'd2,
      DRAIN = 2'd3
   } ser_state_e;

   // Entry is {sys[3:0], par[3:0]}; element k is the entry bit sent as serial bit k.
   localparam logic [2:0] ILV_ORDER [8] = '{3'd7, 3'd3, 3'd6, 3'd2, 3'd5, 3'd1, 3'd4, 3'd0};

endpackage

// File: rtl/turbo_serializer_pair_buf.sv
// DEPTH x W pair register file: synchronous write, asynchronous read.
// No reset on contents; the serializer never reads an entry it has not written in the current frame.
module pair_buf #(
   parameter int W     = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [W-1:0]             wr_dat,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [W-1:0]             rd_dat
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_dat;
      end
   end

   assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/turbo_serializer.sv
// Buffers one frame of {sys, par} nibble pairs and emits them as an interleaved rate-1/2 bitstream.
// First bit valid one cycle after the first capture; ser_ready low stalls the stream with outputs held.
module turbo_serializer
   import turbo_pkg::*;
#(
   parameter int NIB_W = DEF_NIB_W,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             delete_start,
   input  logic             delete_over,
   input  logic [NIB_W-1:0] sys_in,
   input  logic [NIB_W-1:0] par_in,
   output logic             ser_bit,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             ser_sof,
   output logic             ser_eof,
   output logic             busy,
   output logic             short_frame
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = 2 * NIB_W;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   ser_state_e    state, state_nxt;
   logic [CW-1:0] wr_cnt, wr_cnt_nxt;
   logic [CW-1:0] rd_entry, rd_entry_nxt;
   logic [2:0]    bit_idx, bit_idx_nxt;
   logic          short_nxt;
   logic          wr_en;
   logic          cap_ok;
   logic          fire;
   logic [EW-1:0] rd_dat;

   pair_buf #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_pair_buf (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_cnt[AW-1:0]),
      .wr_dat  ({sys_in, par_in}),
      .rd_addr (rd_entry[AW-1:0]),
      .rd_dat  (rd_dat)
   );

   always_comb begin
      busy      = (state == FILL) || (state == DRAIN);
      ser_valid = busy && (rd_entry < wr_cnt);
      ser_bit   = ser_valid && rd_dat[ILV_ORDER[bit_idx]];
      ser_sof   = ser_valid && (rd_entry == '0) && (bit_idx == 3'd0);
      // eof only once the frame is closed, so a still-filling frame never ends early
      ser_eof   = ser_valid && (state == DRAIN) && (rd_entry == wr_cnt - 1'b1) && (bit_idx == 3'd7);
      fire      = ser_valid && ser_ready;
      cap_ok    = delete_start && !delete_over;
   end

   always_comb begin
      state_nxt    = state;
      wr_cnt_nxt   = wr_cnt;
      rd_entry_nxt = rd_entry;
      bit_idx_nxt  = bit_idx;
      short_nxt    = short_frame;
      wr_en        = 1'b0;

      if (fire) begin
         bit_idx_nxt = bit_idx + 3'd1;
         if (bit_idx == 3'd7) begin
            rd_entry_nxt = rd_entry + 1'b1;
         end
      end

      case (state)
         REARM: begin
            wr_cnt_nxt   = '0;
            rd_entry_nxt = '0;
            bit_idx_nxt  = '0;
            if (!delete_start) begin
               state_nxt = IDLE;
            end
         end
         IDLE: begin
            wr_cnt_nxt   = '0;
            rd_entry_nxt = '0;
            bit_idx_nxt  = '0;
            if (cap_ok) begin
               wr_en      = 1'b1;
               wr_cnt_nxt = {{(CW-1){1'b0}}, 1'b1};
               short_nxt  = 1'b0;
               state_nxt  = FILL;
            end
         end
         FILL: begin
            if (cap_ok && (wr_cnt < FULL)) begin
               wr_en      = 1'b1;
               wr_cnt_nxt = wr_cnt + 1'b1;
            end
            if ((wr_cnt_nxt == FULL) || !cap_ok) begin
               state_nxt = DRAIN;
               short_nxt = (wr_cnt_nxt != FULL);
            end
         end
         DRAIN: begin
            if (fire && ser_eof) begin
               state_nxt    = REARM;
               wr_cnt_nxt   = '0;
               rd_entry_nxt = '0;
               bit_idx_nxt  = '0;
            end
         end
         default: state_nxt = REARM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= REARM;
         wr_cnt      <= '0;
         rd_entry    <= '0;
         bit_idx     <= '0;
         short_frame <= 1'b0;
      end else begin
         state       <= state_nxt;
         wr_cnt      <= wr_cnt_nxt;
         rd_entry    <= rd_entry_nxt;
         bit_idx     <= bit_idx_nxt;
         short_frame <= short_nxt;
      end
   end

endmodule
